// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight write tracking for a scalar pipeline.
// One CNT_W-bit counter per architectural register x1..x31 counts writes that
// have left ID but not yet committed at MEM/WB. ID is held (stall) while a
// source it reads is still pending, or while its own destination counter is
// saturated.
//
// Optional feature, macro SCOREBOARD_WB_BYPASS_EN: a source whose counter is 1
// and whose write retires at MEM/WB in the same cycle is treated as ready.
//
// Handshake: issue_valid is the request and !stall is the ready. An issue is
// accepted only in a cycle with issue_valid=1 and stall=0. A stalled issue
// leaves every counter untouched, and the requester must hold its inputs.
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic       issue_reg_we,
  input  logic [4:0] issue_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       wb_reg_we,
  input  logic [4:0] wb_rd,
  input  logic       flush,
  output logic       stall,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Entry 0 exists only to keep indexing uniform; it is held at zero.
  logic [CNT_W-1:0] r_cnt [32];
  logic             r_busy;

  logic [CNT_W-1:0] w_cnt_nxt [32];
  logic [CNT_W-1:0] w_rs1_cnt;
  logic [CNT_W-1:0] w_rs2_cnt;
  logic [CNT_W-1:0] w_rd_cnt;
  logic [CNT_W-1:0] w_wb_cnt;
  logic             w_rs1_haz;
  logic             w_rs2_haz;
  logic             w_rd_sat;
  logic             w_stall;
  logic             w_inc;
  logic             w_dec;
  logic             w_any_nxt;

  assign w_rs1_cnt = r_cnt[id_rs1];
  assign w_rs2_cnt = r_cnt[id_rs2];
  assign w_rd_cnt  = r_cnt[issue_rd];
  assign w_wb_cnt  = r_cnt[wb_rd];

  // Source hazard detection, optionally forgiving a retiring last write.
  always_comb begin
    w_rs1_haz = id_uses_rs1 && (id_rs1 != 5'd0) && (w_rs1_cnt != '0);
    w_rs2_haz = id_uses_rs2 && (id_rs2 != 5'd0) && (w_rs2_cnt != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    if ((w_rs1_cnt == CNT_ONE) && wb_reg_we && (wb_rd == id_rs1))
      w_rs1_haz = 1'b0;
    if ((w_rs2_cnt == CNT_ONE) && wb_reg_we && (wb_rd == id_rs2))
      w_rs2_haz = 1'b0;
`endif
  end

  assign w_rd_sat = issue_valid && issue_reg_we && (issue_rd != 5'd0) &&
                    (w_rd_cnt == CNT_MAX);
  assign w_stall  = w_rs1_haz || w_rs2_haz || w_rd_sat;
  assign stall    = w_stall;

  // Accepted destination write and committing writeback (never underflows).
  assign w_inc = issue_valid && !w_stall && issue_reg_we && (issue_rd != 5'd0);
  assign w_dec = wb_reg_we && (wb_rd != 5'd0) && (w_wb_cnt != '0);

  // Next counter values; an increment and decrement on one register cancel.
  always_comb begin
    w_any_nxt = 1'b0;
    for (int i = 0; i < 32; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (i != 0) begin
        if (w_inc && (issue_rd == 5'(i)))
          w_cnt_nxt[i] = w_cnt_nxt[i] + CNT_ONE;
        if (w_dec && (wb_rd == 5'(i)))
          w_cnt_nxt[i] = w_cnt_nxt[i] - CNT_ONE;
      end else begin
        w_cnt_nxt[i] = '0;
      end
      w_any_nxt = w_any_nxt | (w_cnt_nxt[i] != '0);
    end
  end

  // Counter state and registered busy; reset beats flush beats normal update.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
      r_busy <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_busy <= w_any_nxt;
    end
  end

  assign busy = r_busy;

endmodule
